// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction and data requesters,
// data-first with a starvation guard, sticky timeout error on long stalls.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] TLIM = BW'(TIMEOUT);
    localparam logic [1:0] ACCESS = 2'd2;
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    state_t state;
    logic [SW-1:0] starve;
    logic [BW-1:0] busy;
    logic idone, ddone;
    always_comb begin
        idone = state == IACC && ramstate == ACCESS;
        ddone = state == DACC && ramstate == ACCESS;
        iwait = !idone;
        dwait = !ddone;
        iload = idone ? ramload : '0;
        dload = ddone ? ramload : '0;
    end
    // RAM strobes/address/data are registered at the grant edge and double as the access latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            starve   <= '0;
            busy     <= '0;
            err      <= 1'b0;
        end else if (state == IDLE) begin
            busy <= '0;
            if ((dREN || dWEN) && starve < SLIM) begin
                state    <= DACC;
                ramREN   <= !dWEN;
                ramWEN   <= dWEN;
                ramaddr  <= daddr;
                ramstore <= dstore;
                starve   <= iREN ? starve + 1'b1 : '0;
            end else if (iREN) begin
                state   <= IACC;
                ramREN  <= 1'b1;
                ramaddr <= iaddr;
                starve  <= '0;
            end else begin
                starve <= '0;
            end
        end else if (ramstate == ACCESS) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            busy     <= '0;
        end else begin
            busy <= busy == TLIM ? busy : busy + 1'b1;
            if (busy == TLIM - 1'b1) err <= 1'b1;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive data grants allowed while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 255: number of BUSY cycles in one access before the sticky error flag sets.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 iREN  in  1  instruction read request, held until iwait is low.
REQ-006 iaddr  in  32  instruction address.
REQ-007 iwait  out  1  instruction stall; low for exactly the completion cycle.
REQ-008 iload  out  32  instruction read data, valid while iwait is low.
REQ-009 dREN  in  1  data read request.
REQ-010 dWEN  in  1  data write request.
REQ-011 daddr  in  32  data address.
REQ-012 dstore  in  32  data write value.
REQ-013 dwait  out  1  data stall; low for exactly the completion cycle.
REQ-014 dload  out  32  data read data, valid while dwait is low.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, IACC and DACC.
REQ-023 IDLE transitions:
- data request (dREN|dWEN) and starve count < STARVE_LIMIT -> DACC;
- otherwise iREN -> IACC;
- otherwise stay in IDLE.
REQ-024 At the grant edge, the arbiter SHALL latch the address, the write data and the operation (dWEN wins over dREN; asserting both is illegal and is performed as a write).
REQ-025 In IACC, ramREN=1, ramWEN=0 and ramaddr=latched iaddr.
REQ-026 In DACC, ramREN or ramWEN follows the latched operation, ramaddr=latched daddr and ramstore=latched dstore.
REQ-027 In IDLE, ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-028 When ramstate==ACCESS in IACC (DACC), iwait (dwait) SHALL be 0 that cycle, iload (dload)=ramload, and the next state SHALL be IDLE.
REQ-029 In all other cycles, iwait=1, dwait=1, iload=0 and dload=0.
REQ-030 Minimum latency: request seen in IDLE at cycle N, RAM driven at N+1, wait low at N+1 if ramstate==ACCESS.
REQ-031 A back-to-back request SHALL be regranted no earlier than one IDLE cycle after completion.
REQ-032 ramstate ERROR in IACC/DACC: the arbiter SHALL hold state and keep the strobes asserted (retry) until ACCESS.
REQ-033 A busy counter SHALL count cycles in IACC/DACC without ACCESS and clear on entering IDLE.
REQ-034 When the busy counter reaches TIMEOUT, err SHALL set and remain set until reset; the access continues.
REQ-035 Starve counter:
- increments (saturating at STARVE_LIMIT) on each DACC grant taken while iREN=1;
- clears on an IACC grant;
- clears in IDLE when iREN=0.
REQ-036 With the starve count at STARVE_LIMIT and both requests pending, IDLE SHALL grant IACC.
REQ-037 A requester dropping its request after the grant does not abort the access: it completes and its wait pulse is still produced.
REQ-038 Latched address and data SHALL NOT change while in IACC/DACC regardless of input changes.

Reset
REQ-039 RST high at a clock edge forces IDLE regardless of the current state (including mid-access).
REQ-040 The same edge clears the starve counter, the busy counter, err and all latched address/data registers.
REQ-041 During and immediately after reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, err=0.

Verification
REQ-042 Instruction read: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait low for one cycle at cycle 3 with iload=0xDEADBEEF.
REQ-043 Collision: iREN and dWEN both high from IDLE, daddr=0x80, dstore=0x1234 -> DACC first with ramWEN=1 and ramstore=0x1234; IACC follows after one IDLE cycle.
REQ-044 Starvation: iREN held, dREN re-asserted continuously, STARVE_LIMIT=4, RAM always ACCESS -> 4 data completions, then one instruction completion, then data resumes.
REQ-045 Timeout and error: ramstate BUSY for 256 cycles in DACC -> err=1 from cycle 255 of BUSY; ERROR injected for 3 cycles then ACCESS -> strobes held throughout, one dwait-low pulse.
REQ-046 Reset mid-access: RST high in DACC with ramWEN=1 -> next cycle ramWEN=0, state IDLE, err=0, no dwait pulse.
